// File: rtl/wrr_lock_arb.sv
// wrr_lock_arb -- weighted round-robin arbiter with packet lock and stall timeout.
//
// N_INPUT masters compete for one downstream port. Each requester may win up
// to its weight in consecutive packets per turn. A multi-beat packet (last_i
// low on an accepted beat) locks the grant to its owner until the last beat
// is accepted. An unlocked grant that stalls for TIMEOUT_CYCLE cycles is
// skipped forward so one slow consumer path cannot starve the others.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   req_i      per-requester request
//   last_i     per-requester end-of-packet flag, sampled with the accepted beat
//   weight_i   packets per turn, slice i is requester i (0 behaves as 1)
//   accept_i   downstream consumes the granted beat this cycle
//   gnt_o      one-hot grant, all-zero when gnt_vld_o is low
//   gnt_idx_o  index of the granted requester
//   gnt_vld_o  a grant is valid
//   locked_o   arbiter is locked mid-packet
//   ptr_o      current round-robin pointer
module wrr_lock_arb #(
  parameter int N_INPUT       = 4,
  parameter int WEIGHT_WIDTH  = 4,
  parameter int LOCK_EN       = 1,
  parameter int TIMEOUT_CYCLE = 16,
  localparam int IDX_W        = $clog2(N_INPUT)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_INPUT-1:0]              req_i,
  input  logic [N_INPUT-1:0]              last_i,
  input  logic [N_INPUT*WEIGHT_WIDTH-1:0] weight_i,
  input  logic                            accept_i,
  output logic [N_INPUT-1:0]              gnt_o,
  output logic [IDX_W-1:0]                gnt_idx_o,
  output logic                            gnt_vld_o,
  output logic                            locked_o,
  output logic [IDX_W-1:0]                ptr_o
);

  localparam int TO_W = (TIMEOUT_CYCLE > 0) ? $clog2(TIMEOUT_CYCLE + 1) : 1;

  logic [IDX_W-1:0]        ptr_q;
  logic [WEIGHT_WIDTH-1:0] credit_q;   // 0 means "reload from weight"
  logic                    lock_q;
  logic [IDX_W-1:0]        owner_q;
  logic [TO_W-1:0]         to_cnt_q;

  logic [IDX_W-1:0]        rr_idx;
  logic                    rr_found;
  logic [IDX_W-1:0]        g;
  logic                    vld;
  logic                    beat_acc;
  logic                    eff_last;
  logic [WEIGHT_WIDTH-1:0] w_raw;
  logic [WEIGHT_WIDTH-1:0] w_eff;
  logic [WEIGHT_WIDTH-1:0] c_use;
  logic [IDX_W-1:0]        g_next;
  logic                    stalled;
  logic                    skip;

  // Circular search for the first request at or above ptr_q.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rr_idx   = ptr_q;
    rr_found = 1'b0;
    for (int k = 0; k < N_INPUT; k++) begin
      if (!rr_found && req_i[(int'(ptr_q) + k) % N_INPUT]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'((int'(ptr_q) + k) % N_INPUT);
      end
    end
  end

  // While locked only the owner counts; if it drops req the grant goes
  // invalid but the lock is kept until its last beat.
  assign g   = lock_q ? owner_q : rr_idx;
  assign vld = lock_q ? req_i[owner_q] : rr_found;

  assign beat_acc = vld & accept_i;
  assign eff_last = (LOCK_EN != 0) ? last_i[g] : 1'b1;

  assign w_raw = weight_i[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  assign w_eff = (w_raw == '0) ? WEIGHT_WIDTH'(1) : w_raw;
  // Continue the running turn only if the winner is the pointer holder.
  assign c_use = ((g == ptr_q) && (credit_q != '0)) ? credit_q : w_eff;

  assign g_next = (g == IDX_W'(N_INPUT - 1)) ? '0 : g + 1'b1;

  assign stalled = vld & ~accept_i & ~lock_q;
  assign skip    = (TIMEOUT_CYCLE > 0) && stalled &&
                   (to_cnt_q == TO_W'(TIMEOUT_CYCLE - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      credit_q <= '0;
      lock_q   <= 1'b0;
      owner_q  <= '0;
      to_cnt_q <= '0;
    end else begin
      if (beat_acc) begin
        if (!eff_last) begin
          lock_q  <= 1'b1;
          owner_q <= g;
        end else begin
          // Credit is charged once per packet, on its last beat.
          lock_q <= 1'b0;
          if (c_use > WEIGHT_WIDTH'(1)) begin
            ptr_q    <= g;
            credit_q <= c_use - 1'b1;
          end else begin
            ptr_q    <= g_next;
            credit_q <= '0;
          end
        end
      end else if (skip) begin
        ptr_q    <= g_next;
        credit_q <= '0;
      end

      if ((TIMEOUT_CYCLE > 0) && stalled && !skip)
        to_cnt_q <= to_cnt_q + 1'b1;
      else
        to_cnt_q <= '0;
    end
  end

  assign gnt_o     = vld ? (N_INPUT'(1) << g) : '0;
  assign gnt_idx_o = g;
  assign gnt_vld_o = vld;
  assign locked_o  = lock_q;
  assign ptr_o     = ptr_q;

endmodule
